alu_md_controller: RTL and testbench
====================================

Name: alu_md_controller

Overview:
- Next-generation ALU control block for the RV32 core's EX stage.
- Decodes ALUOp/Funct3/Funct7 into a full RV32I ALU operation code, including all branch compares.
- Adds the M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) through an in-block iterative multiply/divide engine that stalls the pipeline until its result is ready.

Parameters:
- XLEN, 32, datapath width for the multiply/divide engine; legal values are any even value ≥ 8.
- ENABLE_M, 1, when 0 an M-encoded instruction is reported illegal and the engine never starts.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- ALUOp  in  2  00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI
- Funct7  in  7  instruction[31:25]
- Funct3  in  3  instruction[14:12]
- IsImm  in  1  1 = I-type ALU instruction (Funct7 only meaningful for SRAI/SRLI)
- ValidEx  in  1  EX stage holds a valid instruction
- Flush  in  1  kill the EX instruction; abort any engine operation
- Rs1  in  XLEN  operand A
- Rs2  in  XLEN  operand B
- Operation  out  4  ALU operation code (pkg encoding)
- MdSel  out  1  1 = writeback takes MdResult instead of the ALU result
- MdResult  out  XLEN  multiply/divide result, valid when MdDone=1
- MdDone  out  1  one-cycle pulse; result valid this cycle
- Stall  out  1  hold IF/ID/EX; EX operands must remain stable
- Illegal  out  1  unsupported Funct7/Funct3 combination under ALUOp=10

Behaviour:
- Operation decode is combinational from ALUOp/Funct3/Funct7/IsImm:
  - ALUOp=00 or 11 → ADD.
  - ALUOp=01 → BEQ/BNE/BLT/BGE/BLTU/BGEU by Funct3; Funct3 010/011 → Illegal, Operation=ADD.
  - ALUOp=10 → R/I ops. SUB only when !IsImm and Funct7=0100000. SRA when Funct3=101 and Funct7=0100000. Other non-zero Funct7 (except M) → Illegal, Operation=ADD.
- M-op: ALUOp=10, !IsImm, Funct7=0000001, ENABLE_M=1. When ENABLE_M=0 the same encoding raises Illegal.
- Reset: state=IDLE, Stall=0, MdDone=0, MdResult=0, all engine registers 0.
- FSM states: IDLE, CALC, DONE.
- IDLE → CALC on ValidEx && M-op && !Flush:
  - latch |Rs1|, |Rs2| (sign-adjusted per op signedness), result-sign flags, Funct3.
  - counter=XLEN-1.
- IDLE → DONE directly on the division fast paths:
  - divide-by-zero: quotient = all ones, remainder = Rs1.
  - signed overflow (Rs1=MIN, Rs2=-1): quotient = MIN, remainder = 0.
- CALC performs one step per cycle:
  - multiply: radix-2 shift-add into a 2·XLEN product.
  - divide: restoring, one quotient bit per cycle.
  - When counter=0 → DONE.
- DONE: final sign correction is applied; MdResult is registered. MUL takes the low half; MULH/MULHSU/MULHU take the high half. MdDone=1 for exactly one cycle, then → IDLE.
- Stall:
  - 1 while (IDLE && ValidEx && M-op && !Flush) or in CALC.
  - 0 in DONE, so the pipeline advances at the end of the DONE cycle and the same instruction is never restarted.
- Latency:
  - Normal M-op: XLEN+1 stall cycles, result in the following DONE cycle (XLEN+2 cycles issue-to-writeback for XLEN=32: 34).
  - Fast path: 1 stall cycle.
- MdSel = M-op && ValidEx, combinational.
- Flush in CALC or DONE → IDLE next cycle, MdDone=0, Stall deasserts that same cycle.
- Reset mid-operation overrides everything → IDLE next edge.
- MULHSU: only Rs1 is treated as signed. DIVU/REMU/MULHU: no sign handling.
- Illegal is combinational and independent of ValidEx; the trap unit qualifies it.

Decomposition:
- Package alu_ctrl_pkg:
  - Operation encoding constants, OP_W=4: AND 0000, OR 0001, ADD 0010, SRA 0011, SUB 0100, SLT 0101, SLL 0110, SLTU 0111, XOR 1000, SRL 1001, BEQ 1010, BNE 1011, BLT 1100, BGE 1101, BLTU 1110, BGEU 1111.
  - ALUOp constants.
  - Funct7 constants: F7_BASE, F7_ALT, F7_MULDIV.
  - md_state_t enum.
- One sub-module, md_iter_engine: the shift-add/restoring datapath plus counter. The parent keeps the decode, FSM and stall logic.

Test Plan:
- ALUOp=10, Funct3=000, Funct7=0100000, IsImm=0 → Operation=0100 (SUB). Same with IsImm=1 → 0010 (ADD), Illegal=0.
- ALUOp=01, Funct3=101 → Operation=1101 (BGE). Funct3=010 → Illegal=1.
- MUL, Rs1=7, Rs2=-3 → Stall high exactly 33 cycles, MdDone one pulse, MdResult=0xFFFFFFEB. MULH with the same operands → 0xFFFFFFFF.
- DIV, Rs1=0x80000000, Rs2=0xFFFFFFFF → one stall cycle, MdResult=0x80000000. REM, Rs1=5, Rs2=0 → MdResult=5.
- DIVU, Rs1=100, Rs2=7 → 14. REMU → 2. Back-to-back M-ops each start only after the previous DONE; no double issue.
- Flush at CALC cycle 10 → Stall=0 next cycle, no MdDone. reset=1 during CALC → all outputs reset values next edge.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALU operation codes, decode constants and engine state type
package alu_ctrl_pkg;
  localparam int OP_W = 4;
  localparam logic [OP_W-1:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_SRA = 4'b0011;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0100, OP_SLT = 4'b0101, OP_SLL = 4'b0110, OP_SLTU = 4'b0111;
  localparam logic [OP_W-1:0] OP_XOR = 4'b1000, OP_SRL = 4'b1001, OP_BEQ = 4'b1010, OP_BNE = 4'b1011;
  localparam logic [OP_W-1:0] OP_BLT = 4'b1100, OP_BGE = 4'b1101, OP_BLTU = 4'b1110, OP_BGEU = 4'b1111;
  localparam logic [1:0] ALU_MEM = 2'b00, ALU_BRANCH = 2'b01, ALU_RTYPE = 2'b10, ALU_JUMP = 2'b11;
  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000, F7_MULDIV = 7'b0000001;
  typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_DONE} md_state_t;
  function automatic logic [OP_W-1:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000: return OP_ADD;
      3'b001: return OP_SLL;
      3'b010: return OP_SLT;
      3'b011: return OP_SLTU;
      3'b100: return OP_XOR;
      3'b101: return OP_SRL;
      3'b110: return OP_OR;
      default: return OP_AND;
    endcase
  endfunction
  function automatic logic [OP_W-1:0] branch_op(input logic [2:0] f3);
    case (f3)
      3'b000: return OP_BEQ;
      3'b001: return OP_BNE;
      3'b100: return OP_BLT;
      3'b101: return OP_BGE;
      3'b110: return OP_BLTU;
      3'b111: return OP_BGEU;
      default: return OP_ADD;
    endcase
  endfunction
endpackage

// File: rtl/alu_md_controller_if.sv
// alu_md_controller_if: EX-stage decode inputs, operands and ALU/MD control outputs
interface alu_md_controller_if #(parameter int XLEN = 32);
  import alu_ctrl_pkg::*;
  logic [1:0] ALUOp;
  logic [6:0] Funct7;
  logic [2:0] Funct3;
  logic IsImm, ValidEx, Flush;
  logic [XLEN-1:0] Rs1, Rs2;
  logic [OP_W-1:0] Operation;
  logic MdSel, MdDone, Stall, Illegal;
  logic [XLEN-1:0] MdResult;
  modport master(output ALUOp, Funct7, Funct3, IsImm, ValidEx, Flush, Rs1, Rs2,
                 input Operation, MdSel, MdResult, MdDone, Stall, Illegal);
  modport slave(input ALUOp, Funct7, Funct3, IsImm, ValidEx, Flush, Rs1, Rs2,
                output Operation, MdSel, MdResult, MdDone, Stall, Illegal);
endinterface

// File: rtl/md_iter_engine.sv
// md_iter_engine: one-bit-per-cycle unsigned shift-add multiplier / restoring divider
module md_iter_engine #(parameter int XLEN = 32) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi_n,
  output logic [XLEN-1:0] lo_n,
  output logic            last
);
  localparam int CW = $clog2(XLEN);
  logic [XLEN-1:0] hi, lo, dvs;
  logic [CW-1:0] cnt;
  logic div_q;
  logic [XLEN:0] sum, trial, diff;
  // hi:lo is the product for multiply, remainder:quotient for divide
  always_comb begin
    sum = {1'b0, hi} + {1'b0, lo[0] ? dvs : '0};
    trial = {hi, lo[XLEN-1]};
    diff = trial - {1'b0, dvs};
    hi_n = div_q ? (diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0]) : sum[XLEN:1];
    lo_n = div_q ? {lo[XLEN-2:0], ~diff[XLEN]} : {sum[0], lo[XLEN-1:1]};
  end
  assign last = cnt == '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
      dvs <= '0;
      cnt <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      hi <= '0;
      lo <= a;
      dvs <= b;
      cnt <= CW'(XLEN - 1);
      div_q <= is_div;
    end else if (step) begin
      hi <= hi_n;
      lo <= lo_n;
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/alu_md_controller.sv
// alu_md_controller: RV32 EX-stage ALU decode plus stalling M-extension multiply/divide
module alu_md_controller import alu_ctrl_pkg::*; #(
  parameter int XLEN = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input logic clk,
  input logic reset,
  alu_md_controller_if.slave bus
);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  md_state_t state, state_n;
  logic f7_dc, alt_ok, mop_enc, mop, r_ill, illegal, alt_sel;
  logic [OP_W-1:0] op_r;
  // immediates reuse the Funct7 bits except for the shift-by-immediate forms
  assign f7_dc = bus.IsImm && bus.Funct3 != 3'b001 && bus.Funct3 != 3'b101;
  assign alt_ok = bus.Funct3 == 3'b101 || (!bus.IsImm && bus.Funct3 == 3'b000);
  assign mop_enc = !bus.IsImm && bus.Funct7 == F7_MULDIV;
  assign mop = ENABLE_M && bus.ALUOp == ALU_RTYPE && mop_enc;
  assign r_ill = !f7_dc && !(bus.Funct7 == F7_BASE || (bus.Funct7 == F7_ALT && alt_ok) || (mop_enc && ENABLE_M));
  assign illegal = bus.ALUOp == ALU_BRANCH ? bus.Funct3[2:1] == 2'b01 : bus.ALUOp == ALU_RTYPE && r_ill;
  assign alt_sel = !f7_dc && bus.Funct7 == F7_ALT;
  assign op_r = mop ? OP_ADD : alt_sel ? (bus.Funct3 == 3'b000 ? OP_SUB : OP_SRA) : base_op(bus.Funct3);
  assign bus.Illegal = illegal;
  assign bus.Operation = (illegal || bus.ALUOp == ALU_MEM || bus.ALUOp == ALU_JUMP) ? OP_ADD :
                         bus.ALUOp == ALU_BRANCH ? branch_op(bus.Funct3) : op_r;
  assign bus.MdSel = mop && bus.ValidEx;
  logic [2:0] f3;
  logic is_div, sa, sb, neg, b_zero, fast, start, load, fast_go, last, finish;
  logic [XLEN-1:0] abs_a, abs_b, fast_res, hi_n, lo_n, calc_res, md_result;
  logic [2*XLEN-1:0] full, prod;
  logic [2:0] f3_q;
  logic neg_q;
  assign f3 = bus.Funct3;
  assign is_div = f3[2];
  assign sa = bus.Rs1[XLEN-1] && (is_div ? !f3[0] : f3 != 3'b011);
  assign sb = bus.Rs2[XLEN-1] && (is_div ? !f3[0] : !f3[1]);
  // remainder takes the dividend's sign; everything else the sign product
  assign neg = (is_div && f3[1]) ? sa : sa ^ sb;
  assign abs_a = sa ? -bus.Rs1 : bus.Rs1;
  assign abs_b = sb ? -bus.Rs2 : bus.Rs2;
  assign b_zero = bus.Rs2 == '0;
  assign fast = is_div && (b_zero || (!f3[0] && bus.Rs1 == MIN && &bus.Rs2));
  assign fast_res = b_zero ? (f3[1] ? bus.Rs1 : '1) : (f3[1] ? '0 : MIN);
  assign start = state == MD_IDLE && bus.ValidEx && mop && !bus.Flush;
  assign load = start && !fast;
  assign fast_go = start && fast;
  assign finish = state == MD_CALC && last && !bus.Flush;
  md_iter_engine #(.XLEN(XLEN)) u_engine (
    .clk(clk), .reset(reset), .load(load), .step(state == MD_CALC), .is_div(is_div),
    .a(abs_a), .b(abs_b), .hi_n(hi_n), .lo_n(lo_n), .last(last)
  );
  assign full = {hi_n, lo_n};
  assign prod = neg_q ? -full : full;
  assign calc_res = !f3_q[2] ? (f3_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]) :
                    f3_q[1] ? (neg_q ? -hi_n : hi_n) : (neg_q ? -lo_n : lo_n);
  always_comb begin
    state_n = state == MD_IDLE ? (start ? (fast ? MD_DONE : MD_CALC) : MD_IDLE) :
              state == MD_CALC ? (bus.Flush ? MD_IDLE : last ? MD_DONE : MD_CALC) : MD_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= MD_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      f3_q <= '0;
      neg_q <= 1'b0;
      md_result <= '0;
    end else begin
      if (load) begin
        f3_q <= f3;
        neg_q <= neg;
      end
      if (fast_go) md_result <= fast_res;
      else if (finish) md_result <= calc_res;
    end
  end
  assign bus.MdResult = md_result;
  assign bus.MdDone = state == MD_DONE && !bus.Flush;
  assign bus.Stall = !reset && !bus.Flush && ((state == MD_IDLE && bus.ValidEx && mop) || state == MD_CALC);
endmodule

// File: tb/tb_alu_md_controller.sv
// tb_alu_md_controller: random decode and M-op stimulus checked against a behavioural model
module tb_alu_md_controller;
  logic clk = 1'b0, reset = 1'b1;
  int tests = 0, fails = 0;
  bit chk_en = 1'b0;
  logic exp_stall = 1'b0, exp_done = 1'b0;
  logic [31:0] exp_res = '0;
  alu_md_controller_if #(.XLEN(32)) bus();
  alu_md_controller #(.XLEN(32), .ENABLE_M(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic bit is_mop(input logic [1:0] aluop, input logic [6:0] f7, input logic imm);
    return aluop == 2'b10 && !imm && f7 == 7'b0000001;
  endfunction
  // {Illegal, Operation} straight from the instruction-class rules
  function automatic logic [4:0] dec_model(input logic [1:0] aluop, input logic [6:0] f7,
                                           input logic [2:0] f3, input logic imm);
    if (aluop == 2'b00 || aluop == 2'b11) return 5'b0_0010;
    if (aluop == 2'b01) begin
      case (f3)
        3'd0: return 5'b0_1010;
        3'd1: return 5'b0_1011;
        3'd4: return 5'b0_1100;
        3'd5: return 5'b0_1101;
        3'd6: return 5'b0_1110;
        3'd7: return 5'b0_1111;
        default: return 5'b1_0010;
      endcase
    end
    if (imm && f3 != 3'd1 && f3 != 3'd5) f7 = 7'b0;
    if (is_mop(aluop, f7, imm)) return 5'b0_0010;
    if (f7 == 7'b0100000 && f3 == 3'd0 && !imm) return 5'b0_0100;
    if (f7 == 7'b0100000 && f3 == 3'd5) return 5'b0_0011;
    if (f7 != 7'b0) return 5'b1_0010;
    case (f3)
      3'd0: return 5'b0_0010;
      3'd1: return 5'b0_0110;
      3'd2: return 5'b0_0101;
      3'd3: return 5'b0_0111;
      3'd4: return 5'b0_1000;
      3'd5: return 5'b0_1001;
      3'd6: return 5'b0_0001;
      default: return 5'b0_0000;
    endcase
  endfunction
  function automatic logic [31:0] md_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    p = f3 == 3'd2 ? sa * ub : f3 == 3'd3 ? {32'b0, a} * {32'b0, b} : sa * sb;
    if (!f3[2]) return f3 == 3'd0 ? p[31:0] : p[63:32];
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (f3 == 3'd4) return 32'(sa / sb);
    if (f3 == 3'd5) return a / b;
    if (f3 == 3'd6) return 32'(sa % sb);
    return a % b;
  endfunction
  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction
  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  always @(negedge clk) begin
    if (chk_en) begin
      logic [4:0] dm;
      dm = dec_model(bus.ALUOp, bus.Funct7, bus.Funct3, bus.IsImm);
      check("operation", bus.Operation, dm[3:0]);
      check("illegal", bus.Illegal, dm[4]);
      check("mdsel", bus.MdSel, is_mop(bus.ALUOp, bus.Funct7, bus.IsImm) && bus.ValidEx);
      check("stall", bus.Stall, exp_stall);
      check("mddone", bus.MdDone, exp_done);
      if (exp_done) check("mdresult", bus.MdResult, exp_res);
    end
  end
  task automatic set_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bus.ALUOp = 2'b10;
    bus.Funct7 = 7'b0000001;
    bus.IsImm = 1'b0;
    bus.Funct3 = f3;
    bus.Rs1 = a;
    bus.Rs2 = b;
    bus.Flush = 1'b0;
    bus.ValidEx = 1'b1;
  endtask
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input bit has_lit, input logic [31:0] lit);
    set_mop(f3, a, b);
    exp_stall = 1'b1;
    exp_done = 1'b0;
    repeat (is_fast(f3, a, b) ? 1 : 33) tick();
    exp_stall = 1'b0;
    exp_done = 1'b1;
    exp_res = md_model(f3, a, b);
    if (has_lit) begin
      #2;
      check("md_literal", bus.MdResult, lit);
    end
    tick();
    bus.ValidEx = 1'b0;
    exp_done = 1'b0;
  endtask
  task automatic dec_lit(input logic [1:0] aluop, input logic [6:0] f7, input logic [2:0] f3,
                         input logic imm, input logic [3:0] op, input logic ill);
    bus.ALUOp = aluop;
    bus.Funct7 = f7;
    bus.Funct3 = f3;
    bus.IsImm = imm;
    bus.ValidEx = 1'b0;
    #2;
    check("dec_lit_op", bus.Operation, op);
    check("dec_lit_ill", bus.Illegal, ill);
    tick();
  endtask
  initial begin
    bus.ALUOp = 2'b00;
    bus.Funct7 = '0;
    bus.Funct3 = '0;
    bus.IsImm = 1'b0;
    bus.ValidEx = 1'b0;
    bus.Flush = 1'b0;
    bus.Rs1 = '0;
    bus.Rs2 = '0;
    repeat (2) tick();
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_stall", bus.Stall, 1'b0);
    check("rst_done", bus.MdDone, 1'b0);
    check("rst_result", bus.MdResult, 32'd0);
    dec_lit(2'b10, 7'b0100000, 3'b000, 1'b0, 4'b0100, 1'b0);
    dec_lit(2'b10, 7'b0100000, 3'b000, 1'b1, 4'b0010, 1'b0);
    dec_lit(2'b01, 7'b0000000, 3'b101, 1'b0, 4'b1101, 1'b0);
    dec_lit(2'b01, 7'b0000000, 3'b010, 1'b0, 4'b0010, 1'b1);
    dec_lit(2'b10, 7'b0100000, 3'b101, 1'b1, 4'b0011, 1'b0);
    dec_lit(2'b10, 7'b0000010, 3'b110, 1'b0, 4'b0010, 1'b1);
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB);
    issue(3'd1, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000);
    issue(3'd6, 32'd5, 32'd0, 1'b1, 32'd5);
    issue(3'd5, 32'd100, 32'd7, 1'b1, 32'd14);
    issue(3'd7, 32'd100, 32'd7, 1'b1, 32'd2);
    // abort in CALC: no result may appear afterwards
    set_mop(3'd0, 32'd123, 32'd456);
    exp_stall = 1'b1;
    repeat (11) tick();
    bus.Flush = 1'b1;
    exp_stall = 1'b0;
    tick();
    bus.Flush = 1'b0;
    bus.ValidEx = 1'b0;
    repeat (4) tick();
    // a flushed M-op in IDLE must not start
    set_mop(3'd5, 32'd9, 32'd2);
    bus.Flush = 1'b1;
    tick();
    bus.Flush = 1'b0;
    bus.ValidEx = 1'b0;
    repeat (3) tick();
    // reset mid-operation clears the previous nonzero result
    set_mop(3'd1, 32'hDEAD_BEEF, 32'h1234_5678);
    exp_stall = 1'b1;
    repeat (6) tick();
    reset = 1'b1;
    bus.ValidEx = 1'b0;
    exp_stall = 1'b0;
    tick();
    reset = 1'b0;
    #2;
    check("rst_mid_result", bus.MdResult, 32'd0);
    tick();
    repeat (150) begin
      bus.ALUOp = 2'($urandom);
      case ($urandom_range(0, 3))
        0: bus.Funct7 = 7'b0000000;
        1: bus.Funct7 = 7'b0100000;
        2: bus.Funct7 = 7'b0000001;
        default: bus.Funct7 = 7'($urandom);
      endcase
      bus.Funct3 = 3'($urandom);
      bus.IsImm = 1'($urandom);
      bus.Rs1 = $urandom;
      bus.Rs2 = $urandom;
      bus.Flush = $urandom_range(0, 7) == 0;
      bus.ValidEx = 1'($urandom) && !is_mop(bus.ALUOp, bus.Funct7, bus.IsImm);
      tick();
    end
    bus.Flush = 1'b0;
    bus.ValidEx = 1'b0;
    tick();
    repeat (40) begin
      issue(3'($urandom), rnd_opnd(), rnd_opnd(), 1'b0, 32'd0);
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
